// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator advancing once per pixel-enable pulse.
// All outputs are registered from the next-state counters so they always match pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_end,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_FP0  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SY0  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_BP0  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_FP0  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SY0  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BP0  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

  logic [CNT_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic             r_hsync, r_vsync, r_video_on, r_line_end, r_frame_start;
  logic             w_h_wrap, w_v_wrap, w_hs_nxt, w_vs_nxt, w_vo_nxt, w_le_nxt, w_fs_nxt;
  phase_t           w_h_ph_nxt, w_v_ph_nxt;

  assign w_h_wrap = r_x == H_LAST;
  assign w_v_wrap = r_y == V_LAST;

  // Reset parks the raster on the last back-porch pixel so the first en lands on (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_video_on    <= 1'b0;
      r_line_end    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= w_hs_nxt;
      r_vsync       <= w_vs_nxt;
      r_video_on    <= w_vo_nxt;
      r_line_end    <= w_le_nxt;
      r_frame_start <= w_fs_nxt;
    end
  end

  always_comb begin
    w_x_nxt    = r_x;
    w_y_nxt    = r_y;
    if (en) begin
      w_x_nxt = w_h_wrap ? '0 : r_x + 1'b1;
      if (w_h_wrap) w_y_nxt = w_v_wrap ? '0 : r_y + 1'b1;
    end
    w_h_ph_nxt = (w_x_nxt < H_FP0) ? ACTIVE : (w_x_nxt < H_SY0) ? FRONT :
                 (w_x_nxt < H_BP0) ? SYNC : BACK;
    w_v_ph_nxt = (w_y_nxt < V_FP0) ? ACTIVE : (w_y_nxt < V_SY0) ? FRONT :
                 (w_y_nxt < V_BP0) ? SYNC : BACK;
  end

  always_comb begin
    w_hs_nxt = (w_h_ph_nxt == SYNC) ? H_POL : ~H_POL;
    w_vs_nxt = (w_v_ph_nxt == SYNC) ? V_POL : ~V_POL;
    w_vo_nxt = (w_h_ph_nxt == ACTIVE) && (w_v_ph_nxt == ACTIVE);
    w_le_nxt = en && w_h_wrap;
    w_fs_nxt = en && w_h_wrap && w_v_wrap;
  end

  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign line_end    = r_line_end;
  assign frame_start = r_frame_start;
endmodule
